// File: rtl/seq_pkg.sv
// Shared types and defaults for the nibble-sequence detector and flag packer.
// Holds the packer FSM state type and the default word/counter widths.
package seq_pkg;

   typedef enum logic {S_IDLE, S_COLLECT} packer_state_t;

   localparam int SEQ_WORD_W = 8;
   localparam int SEQ_CNT_W  = 8;

endpackage

// File: rtl/seq_flag_packer.sv
// Packs a 1-bit flag stream LSB-first into WORD_W-bit words with length/last.
// Ports: clk, rst_n (sync, active-low), in_valid/in_data (flag stream),
//        out_valid/out_word/out_len/out_last (packed word), total_hits (status).
module seq_flag_packer
   import seq_pkg::*;
#(
   parameter int WORD_W = SEQ_WORD_W,
   parameter int CNT_W  = SEQ_CNT_W,
   parameter int LEN_W  = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_data,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_word,
   output logic [LEN_W-1:0]  out_len,
   output logic              out_last,
   output logic [CNT_W-1:0]  total_hits
);

   localparam logic [LEN_W-1:0] LAST_POS = LEN_W'(WORD_W - 1);
   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WORD_W);

   packer_state_t state, state_n;

   logic [LEN_W-1:0]  idx, idx_n;
   logic [WORD_W-1:0] acc, acc_n;
   logic [WORD_W-1:0] acc_ins;
   logic [CNT_W-1:0]  hits_inc;

   logic              valid_n;
   logic [WORD_W-1:0] word_n;
   logic [LEN_W-1:0]  len_n;
   logic              last_n;
   logic [CNT_W-1:0]  hits_n;

   // Positions at and above idx are always 0, so OR-ing inserts the bit.
   assign acc_ins = acc | (WORD_W'(in_data) << idx);

   assign hits_inc = (in_data && (total_hits != '1)) ?
                     total_hits + CNT_W'(1) : total_hits;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      acc_n   = acc;
      valid_n = 1'b0;
      word_n  = out_word;
      len_n   = out_len;
      last_n  = out_last;
      hits_n  = total_hits;

      unique case (state)
         S_IDLE: begin
            if (in_valid) begin
               // First flag of a stream also restarts the hit count.
               acc_n   = WORD_W'(in_data);
               idx_n   = LEN_W'(1);
               hits_n  = CNT_W'(in_data);
               state_n = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (in_valid) begin
               hits_n = hits_inc;
               if (idx == LAST_POS) begin
                  valid_n = 1'b1;
                  word_n  = acc_ins;
                  len_n   = FULL_LEN;
                  last_n  = 1'b0;
                  acc_n   = '0;
                  idx_n   = '0;
               end else begin
                  acc_n = acc_ins;
                  idx_n = idx + LEN_W'(1);
               end
            end else begin
               // idx==0 here yields the zero-length terminator (acc is 0).
               valid_n = 1'b1;
               word_n  = acc;
               len_n   = idx;
               last_n  = 1'b1;
               acc_n   = '0;
               idx_n   = '0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         acc        <= '0;
         out_valid  <= 1'b0;
         out_word   <= '0;
         out_len    <= '0;
         out_last   <= 1'b0;
         total_hits <= '0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         acc        <= acc_n;
         out_valid  <= valid_n;
         out_word   <= word_n;
         out_len    <= len_n;
         out_last   <= last_n;
         total_hits <= hits_n;
      end
   end

endmodule

// File: tb/tb_seq_flag_packer.sv
// Self-checking bench for seq_flag_packer: vector table, corner sequences,
// and randomized streams against a queue-based stream model.
module tb_seq_flag_packer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_data = 1'b0;

   logic       out_valid;
   logic [7:0] out_word;
   logic [3:0] out_len;
   logic       out_last;
   logic [7:0] total_hits;

   logic       s_valid;
   logic [7:0] s_word;
   logic [3:0] s_len;
   logic       s_last;
   logic [3:0] s_hits;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_flag_packer #(.WORD_W(8), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_word(out_word), .out_len(out_len),
      .out_last(out_last), .total_hits(total_hits)
   );

   seq_flag_packer #(.WORD_W(8), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(s_valid), .out_word(s_word), .out_len(s_len),
      .out_last(s_last), .total_hits(s_hits)
   );

   // ---------------- reference model (stream level) ----------------
   bit         m_in = 0;
   bit         m_q[$];
   bit         m_valid = 0;
   logic [7:0] m_word = 0;
   int         m_len = 0;
   bit         m_last = 0;
   int         m_h8 = 0;
   int         m_h4 = 0;

   function automatic logic [7:0] pack_q();
      logic [7:0] w = 0;
      foreach (m_q[i]) w = w + (8'(m_q[i]) << i);
      return w;
   endfunction

   task automatic model_step(input bit r, input bit v, input bit d);
      m_valid = 0;
      if (!r) begin
         m_in = 0; m_q.delete();
         m_word = 0; m_len = 0; m_last = 0;
         m_h8 = 0; m_h4 = 0;
      end else if (v) begin
         if (!m_in) begin
            m_q.delete();
            m_h8 = d; m_h4 = d;
         end else begin
            m_h8 = (m_h8 + d > 255) ? 255 : m_h8 + d;
            m_h4 = (m_h4 + d > 15) ? 15 : m_h4 + d;
         end
         m_q.push_back(d);
         m_in = 1;
         if (m_q.size() == 8) begin
            m_valid = 1; m_word = pack_q(); m_len = 8; m_last = 0;
            m_q.delete();
         end
      end else if (m_in) begin
         m_valid = 1; m_word = pack_q(); m_len = m_q.size(); m_last = 1;
         m_q.delete();
         m_in = 0;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [21:0] dut_vec();
      return {out_valid, out_word, out_len, out_last, total_hits};
   endfunction

   function automatic logic [13:0] word_vec();
      return {out_valid, out_word, out_len, out_last};
   endfunction

   task automatic step(input bit r, input bit v, input bit d);
      rst_n = r; in_valid = v; in_data = d;
      model_step(r, v, d);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          r;
      bit          v;
      bit          d;
      logic [21:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit v, input bit d, input bit ev,
                      input logic [7:0] w, input logic [3:0] l,
                      input bit la, input logic [7:0] h);
      vec_t e;
      e.r = r; e.v = v; e.d = d;
      e.exp = {ev, w, l, la, h};
      tbl.push_back(e);
   endtask

   initial begin
      bit bits8[8];
      // reset with in_valid toggling
      add(0, 1, 1, 0, 8'h00, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, 0, 0, 0);
      // exact word 1,0,1,1,0,0,0,1
      add(1, 1, 1, 0, 8'h00, 0, 0, 1);
      add(1, 1, 0, 0, 8'h00, 0, 0, 1);
      add(1, 1, 1, 0, 8'h00, 0, 0, 2);
      add(1, 1, 1, 0, 8'h00, 0, 0, 3);
      add(1, 1, 0, 0, 8'h00, 0, 0, 3);
      add(1, 1, 0, 0, 8'h00, 0, 0, 3);
      add(1, 1, 0, 0, 8'h00, 0, 0, 3);
      add(1, 1, 1, 1, 8'h8D, 8, 0, 4);
      add(1, 0, 0, 1, 8'h00, 0, 1, 4);
      add(1, 0, 0, 0, 8'h00, 0, 1, 4);
      // partial 1,1,0
      add(1, 1, 1, 0, 8'h00, 0, 1, 1);
      add(1, 1, 1, 0, 8'h00, 0, 1, 2);
      add(1, 1, 0, 0, 8'h00, 0, 1, 2);
      add(1, 0, 0, 1, 8'h03, 3, 1, 2);
      add(1, 0, 0, 0, 8'h03, 3, 1, 2);
      // spanning: 10 ones
      for (int i = 1; i <= 7; i++) add(1, 1, 1, 0, 8'h03, 3, 1, 8'(i));
      add(1, 1, 1, 1, 8'hFF, 8, 0, 8);
      add(1, 1, 1, 0, 8'hFF, 8, 0, 9);
      add(1, 1, 1, 0, 8'hFF, 8, 0, 10);
      add(1, 0, 0, 1, 8'h03, 2, 1, 10);
      add(1, 0, 0, 0, 8'h03, 2, 1, 10);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].v, tbl[i].d);
         check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
      end

      // saturation with the 4-bit counter instance
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 1);
         if (i == 7)  check("sat_word0", word_vec(), {1'b1, 8'hFF, 4'd8, 1'b0});
         if (i == 14) check("sat_at15", s_hits, 4'd15);
         if (i == 15) check("sat_word1", word_vec(), {1'b1, 8'hFF, 4'd8, 1'b0});
      end
      check("sat_hold", s_hits, 4'd15);
      check("sat_wide", total_hits, 8'd20);
      step(1, 0, 0);
      check("sat_tail", word_vec(), {1'b1, 8'h0F, 4'd4, 1'b1});

      // back-to-back streams
      repeat (3) step(1, 1, 1);
      step(1, 0, 0);
      check("b2b_a", word_vec(), {1'b1, 8'h07, 4'd3, 1'b1});
      step(1, 1, 0);
      check("b2b_restart", {out_valid, total_hits}, {1'b0, 8'd0});
      step(1, 1, 1);
      check("b2b_hits", total_hits, 8'd1);
      step(1, 0, 0);
      check("b2b_b", dut_vec(), {1'b1, 8'h02, 4'd2, 1'b1, 8'd1});

      // mid-stream reset discards the partial word
      repeat (5) step(1, 1, 1);
      step(0, 1, 1);
      check("mid_rst", dut_vec(), 22'd0);
      step(1, 0, 0);
      check("mid_noterm", dut_vec(), 22'd0);
      step(1, 1, 1);
      step(1, 0, 0);
      check("mid_next", dut_vec(), {1'b1, 8'h01, 4'd1, 1'b1, 8'd1});

      // randomized streams against the model
      for (int i = 0; i < 3000; i++) begin
         bit r, v, d;
         r = ($urandom_range(0, 63) != 0);
         v = ($urandom_range(0, 4) != 0);
         d = 1'($urandom);
         step(r, v, d);
         check("rand", dut_vec(),
               {m_valid, m_word, 4'(m_len), m_last, 8'(m_h8)});
         check("rand_sat", {s_valid, s_word, s_len, s_last, s_hits},
               {m_valid, m_word, 4'(m_len), m_last, 4'(m_h4)});
      end

      // one more random-pattern exact word checked by packing arithmetic
      for (int i = 0; i < 8; i++) bits8[i] = 1'($urandom);
      step(1, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 1, bits8[i]);
      begin
         logic [7:0] w = 0;
         for (int i = 0; i < 8; i++) w = w | (8'(bits8[i]) << i);
         check("rand_word", word_vec(), {1'b1, w, 4'd8, 1'b0});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
